// File: rtl/uart_pkg.sv
// Shared definitions for the UART message/echo sequencer.
// Optional feature macro: UART_MSG_ECHO_CRLF_EN (adds the LF_PEND state).
package uart_pkg;

  // TX sequencer states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_GAP     = 2'd2
`ifdef UART_MSG_ECHO_CRLF_EN
    ,
    ST_LF_PEND = 2'd3
`endif
  } tx_state_e;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  // Ceiling log2, usable in constant expressions (port widths)
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_msg_echo_if.sv
// Byte-level link between the sequencer and the uart block.
// Handshake: the sequencer raises tx_en with tx_data only while tx_rdy=1 and
// holds both until the uart drops tx_rdy (byte accepted); tx_en then goes low
// for at least one cycle before the next byte. rx_rdy is a one-cycle strobe
// and rx_data is valid only while rx_rdy=1; there is no back-pressure on RX.
interface uart_msg_echo_if;
  logic       tx_rdy;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       rx_rdy;
  logic [7:0] rx_data;

  modport master (input tx_rdy, input rx_rdy, input rx_data,
                  output tx_en, output tx_data);
  modport slave  (output tx_rdy, output rx_rdy, output rx_data,
                  input tx_en, input tx_data);
endinterface

// File: rtl/uart_msg_echo_sync_fifo.sv
// Show-ahead synchronous FIFO. A push while full is accepted only if a pop
// happens in the same cycle; otherwise it is discarded (caller sees full).
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [WIDTH-1:0]   push_data,
  input  logic               pop,
  output logic [WIDTH-1:0]   pop_data,
  output logic               full,
  output logic               empty,
  output logic [clog2(DEPTH):0] count
);
  localparam int AW = clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

  // Pointer and occupancy next-state; pointers wrap naturally (power-of-two depth)
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
    else if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
  end

  // Control registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless after reset
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_msg_echo.sv
// Greeting transmitter plus RX echo, sitting in front of the uart block.
// Optional macro UART_MSG_ECHO_CRLF_EN: echoed CR is followed by an inserted LF.
module uart_msg_echo
  import uart_pkg::*;
#(
  parameter int                   MSG_LEN    = 15,
  parameter logic [MSG_LEN*8-1:0] MSG        = "Hello, world!\r\n",
  parameter int                   FIFO_DEPTH = 16,
  parameter int                   AUTO_GREET = 1
) (
  input  logic                        clk_50m,
  input  logic                        rst,
  input  logic                        msg_go,
  input  logic                        clr_ovf,
  uart_msg_echo_if.master             uart,
  output logic                        msg_busy,
  output logic [clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                        overflow,
  output tx_state_e                   state_dbg
);
  localparam int IDX_W = (MSG_LEN > 1) ? clog2(MSG_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

  tx_state_e        state_q, state_d;
  logic             tx_en_q, tx_en_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;
`ifdef UART_MSG_ECHO_CRLF_EN
  logic             lf_q, lf_d;
`endif

  logic             fifo_pop, fifo_full, fifo_empty, drop;
  logic [7:0]       fifo_head;
  logic [MSG_LEN*8-1:0] msg_shift;
  logic [7:0]       msg_char;

  // Character idx of the greeting, first character in the top byte
  assign msg_shift = MSG << {idx_q, 3'b000};
  assign msg_char  = msg_shift[MSG_LEN*8-1 -: 8];

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk_50m),
    .rst       (rst),
    .push      (uart.rx_rdy),
    .push_data (uart.rx_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // A byte is lost only when the FIFO is full and nothing leaves this cycle
  assign drop = uart.rx_rdy && fifo_full && !fifo_pop;

  // TX sequencer next-state: greeting has priority over echo in IDLE
  always_comb begin
    state_d   = state_q;
    tx_en_d   = tx_en_q;
    tx_data_d = tx_data_q;
    idx_d     = idx_q;
    last_d    = last_q;
    busy_d    = busy_q;
    fifo_pop  = 1'b0;
`ifdef UART_MSG_ECHO_CRLF_EN
    lf_d      = lf_q;
`endif
    if (msg_go && !busy_q) busy_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (uart.tx_rdy) begin
          if (busy_q) begin
            tx_data_d = msg_char;
            tx_en_d   = 1'b1;
            last_d    = (idx_q == LAST_IDX);
            idx_d     = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
            state_d   = ST_SEND;
          end else if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            tx_data_d = fifo_head;
            tx_en_d   = 1'b1;
            state_d   = ST_SEND;
`ifdef UART_MSG_ECHO_CRLF_EN
            lf_d      = (fifo_head == CHAR_CR);
`endif
          end
        end
      end
      ST_SEND: begin
        if (!uart.tx_rdy) begin
          tx_en_d = 1'b0;
          state_d = ST_GAP;
          if (last_q) begin
            busy_d = 1'b0;
            last_d = 1'b0;
          end
        end
      end
      ST_GAP: begin
`ifdef UART_MSG_ECHO_CRLF_EN
        state_d = lf_q ? ST_LF_PEND : ST_IDLE;
`else
        state_d = ST_IDLE;
`endif
      end
`ifdef UART_MSG_ECHO_CRLF_EN
      ST_LF_PEND: begin
        if (uart.tx_rdy) begin
          tx_data_d = CHAR_LF;
          tx_en_d   = 1'b1;
          lf_d      = 1'b0;
          state_d   = ST_SEND;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky overflow: a drop in the clearing cycle keeps it set
  always_comb begin
    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  // Sequencer registers; reset kills tx_en immediately
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
      idx_q     <= '0;
      last_q    <= 1'b0;
      busy_q    <= (AUTO_GREET != 0);
      ovf_q     <= 1'b0;
`ifdef UART_MSG_ECHO_CRLF_EN
      lf_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
`ifdef UART_MSG_ECHO_CRLF_EN
      lf_q      <= lf_d;
`endif
    end
  end

  assign uart.tx_en   = tx_en_q;
  assign uart.tx_data = tx_data_q;
  assign msg_busy     = busy_q;
  assign overflow     = ovf_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_uart_msg_echo.sv
// Directed bench for uart_msg_echo (FIFO_DEPTH=4, AUTO_GREET=1).
module tb_uart_msg_echo;
  import uart_pkg::*;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk_50m = 1'b0;
  logic rst     = 1'b1;
  always #10 clk_50m = ~clk_50m;

  logic       msg_go  = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       msg_busy;
  logic [2:0] fifo_count;
  logic       overflow;
  tx_state_e  state_dbg;

  uart_msg_echo_if u();

  uart_msg_echo #(.FIFO_DEPTH(DEPTH), .AUTO_GREET(1)) dut (
    .clk_50m    (clk_50m),
    .rst        (rst),
    .msg_go     (msg_go),
    .clr_ovf    (clr_ovf),
    .uart       (u),
    .msg_busy   (msg_busy),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int tx_pulses = 0;
  int busy_fall_at = -1;
  logic tx_en_prev = 1'b0;
  logic busy_prev  = 1'b0;
  logic tx_block   = 1'b0;

  logic [7:0] greet_tab [15] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20,
                                 8'h77, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0D, 8'h0A};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: every rising edge of tx_en is one transmitted byte
  always @(negedge clk_50m) begin
    if (u.tx_en && !tx_en_prev) begin
      got_q.push_back(u.tx_data);
      tx_pulses++;
    end
    if (busy_prev && !msg_busy) busy_fall_at = tx_pulses;
    tx_en_prev = u.tx_en;
    busy_prev  = msg_busy;
  end

  // UART model: accepts a byte, drops tx_rdy after 2 cycles, frame of 4 more
  initial begin : uart_model
    int cnt;
    logic bfm_busy;
    cnt = 0;
    bfm_busy = 1'b0;
    u.tx_rdy = 1'b1;
    forever begin
      @(posedge clk_50m);
      #1;
      if (rst) begin
        bfm_busy = 1'b0;
        cnt = 0;
        u.tx_rdy = !tx_block;
      end else if (bfm_busy) begin
        cnt++;
        if (cnt == 2) u.tx_rdy = 1'b0;
        if (cnt == 6) begin
          u.tx_rdy = !tx_block;
          bfm_busy = 1'b0;
        end
      end else if (u.tx_en && u.tx_rdy) begin
        bfm_busy = 1'b1;
        cnt = 0;
      end else begin
        u.tx_rdy = !tx_block;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic rx_byte(input logic [7:0] b);
    @(negedge clk_50m);
    u.rx_rdy  = 1'b1;
    u.rx_data = b;
    @(negedge clk_50m);
    u.rx_rdy  = 1'b0;
  endtask

  task automatic pulse_go();
    @(negedge clk_50m);
    msg_go = 1'b1;
    @(negedge clk_50m);
    msg_go = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_50m);
  endtask

  task automatic push_greeting();
    for (int i = 0; i < 15; i++) exp_q.push_back(greet_tab[i]);
  endtask

  // Wait (bounded) for all expected bytes, then compare in order
  task automatic expect_bytes(input string tag, input int budget);
    int n;
    int cyc;
    logic [7:0] e;
    n = exp_q.size();
    cyc = 0;
    while (got_q.size() < n && cyc < budget) begin
      @(negedge clk_50m);
      cyc++;
    end
    check({tag, " arrived"}, 32'(got_q.size() >= n), 32'd1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() > 0) check(tag, 32'(got_q.pop_front()), 32'(e));
      else                  check(tag, 32'h100, 32'(e));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int base;
    int cyc;
    u.rx_rdy  = 1'b0;
    u.rx_data = 8'h00;
    #1;
    idle(3);
    check("rst tx_en",      32'(u.tx_en), 32'd0);
    check("rst tx_data",    32'(u.tx_data), 32'd0);
    check("rst fifo_count", 32'(fifo_count), 32'd0);
    check("rst overflow",   32'(overflow), 32'd0);
    check("rst msg_busy",   32'(msg_busy), 32'd1);
    check("rst state",      32'(state_dbg), 32'(ST_IDLE));
    rst = 1'b0;

    // Auto greeting, with three RX bytes arriving mid-greeting
    idle(20);
    rx_byte(8'h61);
    rx_byte(8'h62);
    rx_byte(8'h63);
    check("rx buffered count", 32'(fifo_count), 32'd3);
    check("busy during greet", 32'(msg_busy), 32'd1);
    push_greeting();
    exp_q.push_back(8'h61);
    exp_q.push_back(8'h62);
    exp_q.push_back(8'h63);
    expect_bytes("greet+echo", 3000);
    check("busy fall after LF", 32'(busy_fall_at), 32'd15);
    idle(20);
    check("fifo drained", 32'(fifo_count), 32'd0);
    check("busy idle", 32'(msg_busy), 32'd0);

    // Overflow with transmitter blocked
    tx_block = 1'b1;
    idle(10);
    for (int i = 0; i < 6; i++) rx_byte(8'h31 + 8'(i));
    check("ovf count full", 32'(fifo_count), 32'd4);
    check("ovf flag", 32'(overflow), 32'd1);
    @(negedge clk_50m);
    u.rx_rdy  = 1'b1;
    u.rx_data = 8'h37;
    clr_ovf   = 1'b1;
    @(negedge clk_50m);
    u.rx_rdy  = 1'b0;
    clr_ovf   = 1'b0;
    check("drop beats clr", 32'(overflow), 32'd1);
    @(negedge clk_50m);
    clr_ovf = 1'b1;
    @(negedge clk_50m);
    clr_ovf = 1'b0;
    check("clr_ovf", 32'(overflow), 32'd0);
    check("nothing sent blocked", 32'(got_q.size()), 32'd0);
    tx_block = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h31 + 8'(i));
    expect_bytes("ovf echo", 1000);
    idle(30);
    check("ovf no extra", 32'(got_q.size()), 32'd0);
    check("ovf fifo empty", 32'(fifo_count), 32'd0);

    // msg_go: second pulse mid-greeting is ignored
    base = tx_pulses;
    pulse_go();
    check("go sets busy", 32'(msg_busy), 32'd1);
    idle(30);
    pulse_go();
    push_greeting();
    expect_bytes("regreet", 3000);
    idle(300);
    check("regreet no extra", 32'(got_q.size()), 32'd0);
    check("regreet busy fall", 32'(busy_fall_at - base), 32'd15);
    check("regreet idle", 32'(msg_busy), 32'd0);

    // CR echo
    rx_byte(8'h0D);
    exp_q.push_back(8'h0D);
`ifdef UART_MSG_ECHO_CRLF_EN
    exp_q.push_back(8'h0A);
`endif
    expect_bytes("cr echo", 1000);
    idle(50);
    check("cr no extra", 32'(got_q.size()), 32'd0);

    // Reset while the 5th greeting character is on the wire
    pulse_go();
    cyc = 0;
    while (got_q.size() < 5 && cyc < 1000) begin
      @(negedge clk_50m);
      cyc++;
    end
    check("5th char tx_en", 32'(u.tx_en), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("async tx_en drop", 32'(u.tx_en), 32'd0);
    check("mid rst busy", 32'(msg_busy), 32'd1);
    for (int i = 0; i < 5; i++) exp_q.push_back(greet_tab[i]);
    expect_bytes("pre-rst chars", 10);
    got_q.delete();
    idle(3);
    rst = 1'b0;
    push_greeting();
    expect_bytes("post-rst greet", 3000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
